// File: rtl/lru_matrix_multiset.sv
// Per-set matrix-LRU replacement tracker with registered victim lookup.
// Ports: clk, rst_n (sync, active-low), flush_i, update_* (touch way as MRU),
//        lookup_* plus way_valid_i/lock_mask_i (victim request),
//        victim_valid_o/victim_way_o/victim_none_o (result one cycle later).
module lru_matrix_multiset #(
    parameter int NUM_SET   = 16,
    parameter int NUM_WAY   = 4,
    parameter int SET_DEPTH = (NUM_SET > 1) ? $clog2(NUM_SET) : 1,
    parameter int WAY_DEPTH = $clog2(NUM_WAY)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 update_valid_i,
    input  logic [SET_DEPTH-1:0] update_set_i,
    input  logic [WAY_DEPTH-1:0] update_way_i,
    input  logic                 lookup_valid_i,
    input  logic [SET_DEPTH-1:0] lookup_set_i,
    input  logic [NUM_WAY-1:0]   way_valid_i,
    input  logic [NUM_WAY-1:0]   lock_mask_i,
    output logic                 victim_valid_o,
    output logic [WAY_DEPTH-1:0] victim_way_o,
    output logic                 victim_none_o
);

    localparam int SET_W1 = SET_DEPTH + 1;

    // mat[s][j][k] = 1: way j used more recently than way k
    logic [NUM_SET-1:0][NUM_WAY-1:0][NUM_WAY-1:0] mat_q, mat_d;

    logic                 victim_valid_q, victim_valid_d;
    logic [WAY_DEPTH-1:0] victim_way_q, victim_way_d;
    logic                 victim_none_q, victim_none_d;

    logic                 upd_in_range;
    logic                 lk_in_range;
    logic [NUM_WAY-1:0]   way_oh;
    logic [NUM_WAY-1:0][NUM_WAY-1:0] lk_rows;
    logic [NUM_WAY-1:0]   elig;
    logic [NUM_WAY-1:0]   inval;
    logic [WAY_DEPTH-1:0] vic_way;
    logic                 vic_none;
    logic                 found;

    // Range checks only matter when NUM_SET is not a power of two
    generate
        if (NUM_SET == (1 << SET_DEPTH)) begin : g_full_range
            assign upd_in_range = 1'b1;
            assign lk_in_range  = 1'b1;
        end else begin : g_part_range
            localparam logic [SET_W1-1:0] SET_LIM = SET_W1'(NUM_SET);
            assign upd_in_range = {1'b0, update_set_i} < SET_LIM;
            assign lk_in_range  = {1'b0, lookup_set_i} < SET_LIM;
        end
    endgenerate

    // Matrix next state: flush wins over a coincident touch
    always_comb begin
        mat_d  = mat_q;
        way_oh = NUM_WAY'(1) << update_way_i;
        if (flush_i) begin
            mat_d = '0;
        end else if (update_valid_i && upd_in_range) begin
            for (int j = 0; j < NUM_WAY; j++) begin
                if (j == int'(update_way_i)) begin
                    mat_d[update_set_i][j] = ~way_oh;
                end else begin
                    mat_d[update_set_i][j] = mat_q[update_set_i][j] & ~way_oh;
                end
            end
        end
    end

    // Victim selection reads the post-update matrix (write-first)
    always_comb begin
        lk_rows  = lk_in_range ? mat_d[lookup_set_i] : '0;
        elig     = ~lock_mask_i;
        inval    = elig & ~way_valid_i;
        vic_way  = '0;
        vic_none = (elig == '0);
        found    = 1'b0;
        if (inval != '0) begin
            for (int j = 0; j < NUM_WAY; j++) begin
                if (!found && inval[j]) begin
                    vic_way = WAY_DEPTH'(j);
                    found   = 1'b1;
                end
            end
        end else begin
            // j is a candidate when it is newer than no eligible way
            for (int j = 0; j < NUM_WAY; j++) begin
                if (!found && elig[j] && ((lk_rows[j] & elig) == '0)) begin
                    vic_way = WAY_DEPTH'(j);
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim_valid_d = lookup_valid_i;
        victim_way_d   = lookup_valid_i ? vic_way  : victim_way_q;
        victim_none_d  = lookup_valid_i ? vic_none : victim_none_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mat_q          <= '0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            victim_none_q  <= 1'b0;
        end else begin
            mat_q          <= mat_d;
            victim_valid_q <= victim_valid_d;
            victim_way_q   <= victim_way_d;
            victim_none_q  <= victim_none_d;
        end
    end

    assign victim_valid_o = victim_valid_q;
    assign victim_way_o   = victim_way_q;
    assign victim_none_o  = victim_none_q;

endmodule
